// File: rtl/ld_sequencer.sv
// Load-class (ld/ldi) control-step generator for Mini-SRC; optional memory-wait abort via LD_SEQ_TIMEOUT_EN.
// Latency: ld 8 cycles, ldi 6 cycles, illegal opcode 4 cycles, each plus one cycle per mem_ready=0 wait.
// Backpressure: mem_ready stalls T1/T6 with strobes held; start is ignored (not queued) while busy.
module ld_sequencer
`ifdef LD_SEQ_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [4:0] opcode,
    input  logic       mem_ready,
    output logic       PCout,
    output logic       PCin,
    output logic       IncPC,
    output logic       MARin,
    output logic       MDRin,
    output logic       MDRout,
    output logic       IRin,
    output logic       Read,
    output logic       Yin,
    output logic       ZLowIn,
    output logic       ZHighIn,
    output logic       ZLowout,
    output logic       Cout,
    output logic       BAout,
    output logic       Gra,
    output logic       Grb,
    output logic       Rin,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic       timeout
);

    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_LDI = 5'b00001;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic read;
        logic y_in;
        logic zlow_in;
        logic zhigh_in;
        logic zlow_out;
        logic c_out;
        logic ba_out;
        logic gra;
        logic grb;
        logic r_in;
        logic done;
    } strb_t;

    state_t     state_q, state_d;
    logic       is_ldi_q, is_ldi_d;
    logic [4:0] cnt_q, cnt_d;
    strb_t      strb_q, strb_d;
    logic       busy_q, busy_d;
    logic       illegal_c;
    logic       waiting;
    logic [4:0] cnt_inc;
`ifdef LD_SEQ_TIMEOUT_EN
    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT_CYCLES - 1);
    logic       timeout_c;
`endif

    function automatic strb_t decode(input state_t s, input logic ldi);
        strb_t o;
        o = '0;
        case (s)
            S_T0: begin o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.zlow_in = 1'b1; end
            S_T1: begin o.zlow_out = 1'b1; o.pc_in = 1'b1; o.read = 1'b1; o.mdr_in = 1'b1; end
            S_T2: begin o.mdr_out = 1'b1; o.ir_in = 1'b1; end
            S_T3: begin o.grb = 1'b1; o.ba_out = 1'b1; o.y_in = 1'b1; end
            S_T4: begin o.c_out = 1'b1; o.zlow_in = 1'b1; o.zhigh_in = 1'b1; end
            S_T5: begin
                o.zlow_out = 1'b1;
                if (ldi) begin
                    o.gra = 1'b1; o.r_in = 1'b1; o.done = 1'b1;
                end else begin
                    o.mar_in = 1'b1;
                end
            end
            S_T6: begin o.read = 1'b1; o.mdr_in = 1'b1; end
            S_T7: begin o.mdr_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; o.done = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    assign waiting = ((state_q == S_T1) || (state_q == S_T6)) && !mem_ready;
    assign cnt_inc = (cnt_q == 5'h1f) ? cnt_q : cnt_q + 5'd1;

    always_comb begin
        state_d   = state_q;
        is_ldi_d  = is_ldi_q;
        cnt_d     = cnt_q;
        illegal_c = 1'b0;
`ifdef LD_SEQ_TIMEOUT_EN
        timeout_c = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0: begin
                state_d = S_T1;
                cnt_d   = 5'd0;
            end
            S_T1: if (mem_ready) state_d = S_T2; else cnt_d = cnt_inc;
            S_T2: state_d = S_T3;
            S_T3: begin
                if ((opcode == OP_LD) || (opcode == OP_LDI)) begin
                    state_d  = S_T4;
                    is_ldi_d = (opcode == OP_LDI);
                end else begin
                    illegal_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                state_d = is_ldi_q ? S_IDLE : S_T6;
                cnt_d   = 5'd0;
            end
            S_T6: if (mem_ready) state_d = S_T7; else cnt_d = cnt_inc;
            S_T7: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef LD_SEQ_TIMEOUT_EN
        // cnt_q counts completed waits, so this is the TIMEOUT_CYCLES-th wait cycle.
        if (waiting && (cnt_q == WAIT_LAST)) begin
            timeout_c = 1'b1;
            state_d   = S_IDLE;
        end
`endif
        if (clr) begin
            state_d  = S_IDLE;
            is_ldi_d = 1'b0;
            cnt_d    = 5'd0;
        end
        strb_d = decode(state_d, is_ldi_d);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            is_ldi_q <= 1'b0;
            cnt_q    <= 5'd0;
            strb_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_ldi_q <= is_ldi_d;
            cnt_q    <= cnt_d;
            strb_q   <= strb_d;
            busy_q   <= busy_d;
        end
    end

    assign PCout   = strb_q.pc_out;
    assign PCin    = strb_q.pc_in;
    assign IncPC   = strb_q.inc_pc;
    assign MARin   = strb_q.mar_in;
    assign MDRin   = strb_q.mdr_in;
    assign MDRout  = strb_q.mdr_out;
    assign IRin    = strb_q.ir_in;
    assign Read    = strb_q.read;
    assign Yin     = strb_q.y_in;
    assign ZLowIn  = strb_q.zlow_in;
    assign ZHighIn = strb_q.zhigh_in;
    assign ZLowout = strb_q.zlow_out;
    assign Cout    = strb_q.c_out;
    assign BAout   = strb_q.ba_out;
    assign Gra     = strb_q.gra;
    assign Grb     = strb_q.grb;
    assign Rin     = strb_q.r_in;
    assign done    = strb_q.done;
    assign busy    = busy_q;
    assign illegal = illegal_c;
`ifdef LD_SEQ_TIMEOUT_EN
    assign timeout = timeout_c;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ld_sequencer.sv
// Scoreboarded random bench for ld_sequencer: per-cycle expected strobe sets built from the instruction's step list.
module tb_ld_sequencer;

    logic       clk = 1'b0;
    logic       clr, start, mem_ready;
    logic [4:0] opcode;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Yin, ZLowIn, ZHighIn;
    logic ZLowout, Cout, BAout, Gra, Grb, Rin, busy, done, illegal, timeout;

    always #5 clk = ~clk;

    ld_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Read(Read), .Yin(Yin), .ZLowIn(ZLowIn),
        .ZHighIn(ZHighIn), .ZLowout(ZLowout), .Cout(Cout), .BAout(BAout), .Gra(Gra),
        .Grb(Grb), .Rin(Rin), .busy(busy), .done(done), .illegal(illegal), .timeout(timeout)
    );

    localparam logic [20:0] M_PCOUT = 21'd1 << 20, M_PCIN = 21'd1 << 19, M_INCPC = 21'd1 << 18;
    localparam logic [20:0] M_MARIN = 21'd1 << 17, M_MDRIN = 21'd1 << 16, M_MDROUT = 21'd1 << 15;
    localparam logic [20:0] M_IRIN = 21'd1 << 14, M_READ = 21'd1 << 13, M_YIN = 21'd1 << 12;
    localparam logic [20:0] M_ZLI = 21'd1 << 11, M_ZHI = 21'd1 << 10, M_ZLO = 21'd1 << 9;
    localparam logic [20:0] M_COUT = 21'd1 << 8, M_BAOUT = 21'd1 << 7, M_GRA = 21'd1 << 6;
    localparam logic [20:0] M_GRB = 21'd1 << 5, M_RIN = 21'd1 << 4, M_BUSY = 21'd1 << 3;
    localparam logic [20:0] M_DONE = 21'd1 << 2, M_ILL = 21'd1 << 1, M_TO = 21'd1;

    // Strobe sets per T-state, straight from the instruction's control-step table.
    localparam logic [20:0] E_T0    = M_PCOUT | M_MARIN | M_INCPC | M_ZLI | M_BUSY;
    localparam logic [20:0] E_T1    = M_ZLO | M_PCIN | M_READ | M_MDRIN | M_BUSY;
    localparam logic [20:0] E_T2    = M_MDROUT | M_IRIN | M_BUSY;
    localparam logic [20:0] E_T3    = M_GRB | M_BAOUT | M_YIN | M_BUSY;
    localparam logic [20:0] E_T4    = M_COUT | M_ZLI | M_ZHI | M_BUSY;
    localparam logic [20:0] E_T5LD  = M_ZLO | M_MARIN | M_BUSY;
    localparam logic [20:0] E_T5LDI = M_ZLO | M_GRA | M_RIN | M_DONE | M_BUSY;
    localparam logic [20:0] E_T6    = M_READ | M_MDRIN | M_BUSY;
    localparam logic [20:0] E_T7    = M_MDROUT | M_GRA | M_RIN | M_DONE | M_BUSY;

    wire [20:0] obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Yin, ZLowIn,
                       ZHighIn, ZLowout, Cout, BAout, Gra, Grb, Rin, busy, done, illegal, timeout};

    logic [20:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    logic [20:0] q_ev[$];
    bit          q_st[$], q_mr[$], q_cl[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one expected vector per cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                logic [20:0] e;
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL strobes cycle=%0d got=%b expected=%b", cyc, obs, e);
                end
            end
        end
    end

    function automatic bit rnd_bit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic [20:0] e, input bit s, input bit m);
        q_ev.push_back(e);
        q_st.push_back(s);
        q_mr.push_back(m);
        q_cl.push_back(1'b0);
    endtask

    // kind: 0 = ld, 1 = ldi, 2 = illegal. Entry 0 is the IDLE cycle where start is sampled.
    task automatic build(input int kind, input int w1, input int w6, input bit noise);
        q_ev.delete(); q_st.delete(); q_mr.delete(); q_cl.delete();
        add('0, 1'b1, rnd_bit());
        add(E_T0, noise & rnd_bit(), rnd_bit());
        for (int i = 0; i <= w1; i++) add(E_T1, noise & rnd_bit(), i == w1);
        add(E_T2, noise & rnd_bit(), rnd_bit());
        add(E_T3 | ((kind == 2) ? M_ILL : 21'd0), noise & rnd_bit(), rnd_bit());
        if (kind != 2) begin
            add(E_T4, noise & rnd_bit(), rnd_bit());
            if (kind == 1) begin
                add(E_T5LDI, noise & rnd_bit(), rnd_bit());
            end else begin
                add(E_T5LD, noise & rnd_bit(), rnd_bit());
                for (int i = 0; i <= w6; i++) add(E_T6, noise & rnd_bit(), i == w6);
                add(E_T7, noise & rnd_bit(), rnd_bit());
            end
        end
    endtask

    // Drives the built sequence; a clr in cycle abort_at ends the instruction there.
    task automatic run(input logic [4:0] op, input int abort_at);
        if (abort_at >= 0 && abort_at < q_ev.size()) begin
            while (q_ev.size() > abort_at + 1) begin
                void'(q_ev.pop_back()); void'(q_st.pop_back());
                void'(q_mr.pop_back()); void'(q_cl.pop_back());
            end
            q_cl[abort_at] = 1'b1;
        end
        for (int i = 0; i < q_ev.size(); i++) begin
            @(posedge clk); #1;
            opcode    = op;
            start     = q_st[i];
            mem_ready = q_mr[i];
            clr       = q_cl[i];
            exp_q.push_back(q_ev[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            clr       = 1'b0;
            mem_ready = rnd_bit();
            exp_q.push_back('0);
        end
    endtask

    function automatic logic [4:0] op_of(input int kind);
        if (kind == 0) return 5'b00000;
        if (kind == 1) return 5'b00001;
        return 5'($urandom_range(2, 31));
    endfunction

    initial begin
        clr = 1'b1; start = 1'b0; mem_ready = 1'b0; opcode = 5'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = (i == 1);
            exp_q.push_back('0);
        end

        build(0, 0, 0, 0); run(5'b00000, -1); idle(1);
        build(1, 0, 0, 0); run(5'b00001, -1); idle(1);
        build(0, 0, 3, 0); run(5'b00000, -1); idle(1);
        build(2, 0, 0, 0); run(5'b00010, -1); idle(2);
        build(0, 0, 0, 0); q_st[5] = 1'b1; run(5'b00000, 5);
        build(1, 2, 0, 1); run(5'b00001, -1);
        build(0, 1, 1, 1); run(5'b00000, -1);
        build(2, 2, 0, 1); run(5'b11111, -1);
        build(0, 4, 0, 1); run(5'b00000, 3);
        idle(1);

`ifdef LD_SEQ_TIMEOUT_EN
        q_ev.delete(); q_st.delete(); q_mr.delete(); q_cl.delete();
        add('0, 1'b1, 1'b0);
        add(E_T0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) add(E_T1 | ((i == 15) ? M_TO : 21'd0), 1'b0, 1'b0);
        run(5'b00000, -1);
        idle(2);
`endif

        for (int n = 0; n < 40; n++) begin
            int kind, ab;
            kind = $urandom_range(0, 2);
            build(kind, $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 12) : -1;
            run(op_of(kind), ab);
            idle($urandom_range(0, 2));
        end

        begin
            int bound;
            bound = 0;
            while (exp_q.size() != 0 && bound < 100) begin
                @(posedge clk);
                bound++;
            end
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL drain pending=%0d required=0", exp_q.size());
            end
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
